// File: rtl/osc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : osc_pkg
// Description : Shared types and constants for the oscilloscope capture path:
//               sample width, trigger controller state encoding and the
//               acquisition mode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package osc_pkg;

   localparam int SAMPLE_W = 12;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PRETRIG  = 3'd1,
      ST_ARMED    = 3'd2,
      ST_POSTTRIG = 3'd3,
      ST_HANDOFF  = 3'd4,
      ST_WAIT_RDY = 3'd5
   } state_t;

   // 2'b11 behaves exactly like normal mode.
   typedef enum logic [1:0] {
      MODE_AUTO       = 2'b00,
      MODE_NORMAL     = 2'b01,
      MODE_SINGLE     = 2'b10,
      MODE_NORMAL_ALT = 2'b11
   } mode_t;

endpackage
`default_nettype wire

// File: rtl/trig_detect.sv
`default_nettype none
// ============================================================================
// Module      : trig_detect
// Description : Level-crossing edge comparator. Remembers the previous
//               accepted sample while enabled and flags a rising or falling
//               crossing of 'level'. The first sample after enable only
//               primes the history and never produces a hit.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               sample, valid  - sample and its qualifier
//               level          - unsigned trigger level
//               edge_sel       - 0 rising, 1 falling
//               enable         - comparator active (ARMED state)
//               hit            - combinational crossing flag for this sample
// Revision    : 1.0 - initial release
// ============================================================================
module trig_detect
   import osc_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic                valid,
   input  logic [SAMPLE_W-1:0] level,
   input  logic                edge_sel,
   input  logic                enable,
   output logic                hit
);

   logic [SAMPLE_W-1:0] prev;
   logic                prev_ok;
   logic                rise;
   logic                fall;

   // History is dropped whenever the comparator is disabled so that each
   // ARMED period starts without a stale previous sample.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         prev    <= '0;
         prev_ok <= 1'b0;
      end else if (valid) begin
         prev    <= sample;
         prev_ok <= 1'b1;
      end
   end

   always_comb begin
      rise = (prev <  level) && (sample >= level);
      fall = (prev >= level) && (sample <  level);
      hit  = enable && valid && prev_ok && (edge_sel ? fall : rise);
   end

endmodule
`default_nettype wire

// File: rtl/trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trigger_ctrl
// Description : Oscilloscope acquisition controller. Streams accepted samples
//               into a circular capture buffer, collects a pre-trigger
//               history, waits for a level crossing (or an auto-mode
//               timeout), completes a DEPTH-sample frame and hands it off to
//               the display snapshot buffer.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               sample, sample_valid- ADC sample stream
//               level, edge_sel     - trigger level and edge polarity
//               mode                - 00 auto, 01/11 normal, 10 single
//               arm                 - start pulse (honoured in IDLE only)
//               rom_ready           - snapshot buffer ready
//               wr_en/addr/data     - capture buffer write port
//               start_addr          - oldest sample of the completed frame
//               rom_read            - one-cycle snapshot request
//               busy, triggered, forced - status
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_ctrl
   import osc_pkg::*;
#(
   parameter int DEPTH        = 512,
   parameter int PRE_SAMPLES  = 256,
   parameter int AUTO_TIMEOUT = 4096
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [SAMPLE_W-1:0]      sample,
   input  logic                     sample_valid,
   input  logic [SAMPLE_W-1:0]      level,
   input  logic                     edge_sel,
   input  logic [1:0]               mode,
   input  logic                     arm,
   input  logic                     rom_ready,
   output logic                     wr_en,
   output logic [$clog2(DEPTH)-1:0] wr_addr,
   output logic [SAMPLE_W-1:0]      wr_data,
   output logic [$clog2(DEPTH)-1:0] start_addr,
   output logic                     rom_read,
   output logic                     busy,
   output logic                     triggered,
   output logic                     forced
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = $clog2(DEPTH + 1);
   localparam int TW   = $clog2(AUTO_TIMEOUT + 1);
   localparam int POST = DEPTH - PRE_SAMPLES - 1;

   localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_SAMPLES - 1);
   localparam logic [CW-1:0] POST_LAST = CW'((POST > 0) ? POST - 1 : 0);
   localparam logic          NO_POST   = (POST == 0);
   localparam logic [TW-1:0] TO_LIMIT  = TW'(AUTO_TIMEOUT);
   localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_SAMPLES);

   state_t          state;
   state_t          nstate;
   mode_t           cur_mode;

   logic [AW-1:0]   ptr;
   logic [AW-1:0]   trig_addr;
   logic [AW-1:0]   trig_src;
   logic [CW-1:0]   cnt;
   logic [TW-1:0]   tcnt;
   logic [1:0]      wcnt;

   logic            accept;
   logic            hit;
   logic            timeout_hit;
   logic            fire;
   logic            pre_done;
   logic            post_done;

   trig_detect u_trig_detect (
      .clk      (clk),
      .rst      (rst),
      .sample   (sample),
      .valid    (sample_valid),
      .level    (level),
      .edge_sel (edge_sel),
      .enable   (state == ST_ARMED),
      .hit      (hit)
   );

   always_comb begin
      cur_mode    = mode_t'(mode);
      accept      = sample_valid && ((state == ST_PRETRIG) ||
                                     (state == ST_ARMED)   ||
                                     (state == ST_POSTTRIG));
      // A genuine crossing wins over a simultaneous timeout.
      timeout_hit = (cur_mode == MODE_AUTO) && (tcnt >= TO_LIMIT);
      fire        = (state == ST_ARMED) && sample_valid && (hit || timeout_hit);
      pre_done    = (state == ST_PRETRIG) && sample_valid && (cnt == PRE_LAST);
      post_done   = ((state == ST_POSTTRIG) && sample_valid && (cnt == POST_LAST)) ||
                    (fire && NO_POST);
      // With no post-trigger samples the frame closes on the trigger itself,
      // before trig_addr has been loaded.
      trig_src    = fire ? ptr : trig_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= nstate;
      end
   end

   always_comb begin
      nstate = state;
      case (state)
         ST_IDLE:     if (arm)       nstate = ST_PRETRIG;
         ST_PRETRIG:  if (pre_done)  nstate = ST_ARMED;
         ST_ARMED:    if (fire)      nstate = NO_POST ? ST_HANDOFF : ST_POSTTRIG;
         ST_POSTTRIG: if (post_done) nstate = ST_HANDOFF;
         ST_HANDOFF:  if (rom_ready) nstate = ST_WAIT_RDY;
         ST_WAIT_RDY: begin
            // wcnt==2 means rom_read was high two cycles ago.
            if (rom_ready && (wcnt == 2'd2)) begin
               nstate = (cur_mode == MODE_SINGLE) ? ST_IDLE : ST_PRETRIG;
            end
         end
         default:     nstate = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         start_addr <= '0;
         rom_read   <= 1'b0;
         busy       <= 1'b0;
         triggered  <= 1'b0;
         forced     <= 1'b0;
         ptr        <= '0;
         trig_addr  <= '0;
         cnt        <= '0;
         tcnt       <= '0;
         wcnt       <= '0;
      end else begin
         wr_en    <= accept;
         rom_read <= (state == ST_HANDOFF) && rom_ready;
         busy     <= (nstate != ST_IDLE);

         if (accept) begin
            wr_addr <= ptr;
            wr_data <= sample;
            ptr     <= ptr + AW'(1);
         end

         // cnt restarts on every phase change of the acquisition.
         if (nstate != state) begin
            cnt <= '0;
         end else if (accept) begin
            cnt <= cnt + CW'(1);
         end

         if ((nstate == ST_PRETRIG) && (state != ST_PRETRIG)) begin
            triggered <= 1'b0;
            forced    <= 1'b0;
            tcnt      <= '0;
         end else if (fire) begin
            trig_addr <= ptr;
            triggered <= 1'b1;
            forced    <= !hit;
         end else if ((state == ST_ARMED) && sample_valid && (tcnt < TO_LIMIT)) begin
            tcnt <= tcnt + TW'(1);
         end

         if ((nstate == ST_HANDOFF) && (state != ST_HANDOFF)) begin
            start_addr <= trig_src - PRE_OFS;
         end

         if (state != ST_WAIT_RDY) begin
            wcnt <= '0;
         end else if (wcnt != 2'd2) begin
            wcnt <= wcnt + 2'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trigger_ctrl
// Description : Self-checking bench for trigger_ctrl. Each scenario builds a
//               sample sequence, a reference model scans it for the trigger
//               point, and the recorded buffer writes, start_addr, status
//               flags and snapshot requests are compared with the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_ctrl;
   import osc_pkg::*;

   localparam int DEPTH = 512;
   localparam int PRE   = 256;
   localparam int AUTO  = 4096;
   localparam int SLEN  = 8192;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] sample = '0;
   logic        sample_valid = 1'b0;
   logic [11:0] level = '0;
   logic        edge_sel = 1'b0;
   logic [1:0]  mode = 2'b01;
   logic        arm = 1'b0;
   logic        rom_ready = 1'b1;
   logic        wr_en;
   logic [8:0]  wr_addr;
   logic [11:0] wr_data;
   logic [8:0]  start_addr;
   logic        rom_read;
   logic        busy;
   logic        triggered;
   logic        forced;

   trigger_ctrl #(.DEPTH(DEPTH), .PRE_SAMPLES(PRE), .AUTO_TIMEOUT(AUTO)) dut (
      .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
      .level(level), .edge_sel(edge_sel), .mode(mode), .arm(arm),
      .rom_ready(rom_ready), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .start_addr(start_addr), .rom_read(rom_read),
      .busy(busy), .triggered(triggered), .forced(forced)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int s [SLEN];
   int exp_ptr = 0;

   // Write/snapshot monitor, sampled on the falling edge.
   logic [8:0]  qa [$];
   logic [11:0] qd [$];
   int          rom_cnt = 0;
   int          rom_wide = 0;
   int          b2b_wr = 0;
   logic        prev_wr = 1'b0;
   logic        prev_rr = 1'b0;

   always @(negedge clk) begin
      if (wr_en) begin
         qa.push_back(wr_addr);
         qd.push_back(wr_data);
      end
      if (wr_en && prev_wr)    b2b_wr++;
      if (rom_read)            rom_cnt++;
      if (rom_read && prev_rr) rom_wide++;
      prev_wr = wr_en;
      prev_rr = rom_read;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1);
   end

   // Reference: scan accepted samples counted from arm. Index PRE is the first
   // ARMED sample (primes history only); auto mode forces after AUTO samples.
   function automatic void model(input int md, input int es, input int lvl,
                                 output int tidx, output int frc);
      int tc;
      tc   = 0;
      tidx = -1;
      frc  = 0;
      for (int i = PRE; i < SLEN - DEPTH; i++) begin
         bit h;
         h = 1'b0;
         if (i > PRE) begin
            if (es == 0) h = (s[i-1] <  lvl) && (s[i] >= lvl);
            else         h = (s[i-1] >= lvl) && (s[i] <  lvl);
         end
         if (h) begin
            tidx = i;
            return;
         end
         if ((md == 0) && (tc >= AUTO)) begin
            tidx = i;
            frc  = 1;
            return;
         end
         tc++;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; arm = 1'b0; sample_valid = 1'b0; rom_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      exp_ptr = 0;
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   // gap: 0 = continuous, 1 = random idle cycles, 2 = strict valid/idle alternation
   task automatic feed(input int from, input int n, input int gap);
      for (int k = 0; k < n; k++) begin
         if ((gap == 1) && ($urandom_range(0, 3) == 0)) begin
            sample_valid = 1'b0;
            tick();
         end
         sample = 12'(s[from + k]);
         sample_valid = 1'b1;
         tick();
         if (gap == 2) begin
            sample_valid = 1'b0;
            tick();
         end
      end
      sample_valid = 1'b0;
   endtask

   task automatic wait_rom(input int maxc, output bit seen, output logic [8:0] sa,
                           output logic trg, output logic frc);
      seen = 1'b0; sa = '0; trg = 1'b0; frc = 1'b0;
      for (int c = 0; c < maxc; c++) begin
         @(negedge clk);
         if (rom_read) begin
            seen = 1'b1; sa = start_addr; trg = triggered; frc = forced;
            break;
         end
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < SLEN; i++) s[i] = int'($urandom_range(0, 4095));
   endtask

   // One complete acquisition checked against the model.
   task automatic test_frame(input string nm, input int md, input int es, input int lvl,
                             input bit do_arm, input int gap, input bit hold_ready);
      int tidx, efrc, n, q0, r0, w0, errs, exp_sa;
      bit seen;
      logic [8:0] sa;
      logic trg, frc;
      mode = 2'(md); edge_sel = es[0]; level = 12'(lvl);
      rom_ready = !hold_ready;
      model(md, es, lvl, tidx, efrc);
      if (tidx < 0) tidx = SLEN - DEPTH;
      n  = tidx + DEPTH - PRE;
      q0 = qa.size(); r0 = rom_cnt; w0 = rom_wide;
      if (do_arm) pulse_arm();
      feed(0, n, gap);
      if (hold_ready) begin
         repeat (30) @(negedge clk);
         tests++;
         if ((rom_cnt != r0) || (busy !== 1'b1))
            $display("FAIL %s_hold: rom_reads=%0d busy=%b, required rom_reads=0 busy=1",
                     nm, rom_cnt - r0, busy);
         if ((rom_cnt != r0) || (busy !== 1'b1)) fails++;
         rom_ready = 1'b1;
      end
      wait_rom(100, seen, sa, trg, frc);
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s_rom_read: no rom_read within 100 cycles", nm);
      end
      tests++;
      if (qa.size() - q0 != n) begin
         fails++;
         $display("FAIL %s_write_count: got %0d writes, required %0d", nm, qa.size() - q0, n);
      end
      errs = 0;
      for (int i = 0; (i < n) && (q0 + i < qa.size()); i++) begin
         if ((qa[q0+i] !== 9'((exp_ptr + i) % DEPTH)) || (qd[q0+i] !== 12'(s[i]))) errs++;
      end
      tests++;
      if (errs != 0) begin
         fails++;
         $display("FAIL %s_write_data: %0d address/data errors, required 0", nm, errs);
      end
      exp_sa = (exp_ptr + tidx - PRE + DEPTH) % DEPTH;
      tests++;
      if (sa !== 9'(exp_sa)) begin
         fails++;
         $display("FAIL %s_start_addr: got %0d, required %0d", nm, sa, exp_sa);
      end
      tests++;
      if ((trg !== 1'b1) || (frc !== efrc[0])) begin
         fails++;
         $display("FAIL %s_flags: triggered=%b forced=%b, required triggered=1 forced=%0d",
                  nm, trg, frc, efrc);
      end
      repeat (6) tick();
      tests++;
      if ((rom_cnt - r0 != 1) || (rom_wide != w0)) begin
         fails++;
         $display("FAIL %s_rom_pulse: pulses=%0d wide=%0d, required pulses=1 wide=0",
                  nm, rom_cnt - r0, rom_wide - w0);
      end
      exp_ptr = (exp_ptr + n) % DEPTH;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      tests++;
      if ({wr_en, wr_addr, wr_data, start_addr, rom_read, busy, triggered, forced} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got wr_en=%b wr_addr=%0d wr_data=%0d start=%0d rom_read=%b busy=%b trig=%b forced=%b, required all 0",
                  wr_en, wr_addr, wr_data, start_addr, rom_read, busy, triggered, forced);
      end
      rst = 1'b0;
      exp_ptr = 0;
   endtask

   task automatic test_rising_ramp();
      do_reset();
      for (int i = 0; i < SLEN; i++) s[i] = (i * 16) % 4096;
      test_frame("rising_ramp", 1, 0, 2048, 1'b1, 1, 1'b0);
   endtask

   task automatic test_falling_pretrig_step();
      do_reset();
      for (int i = 0; i < SLEN; i++)
         s[i] = (i < 100) ? 1000 : (i < 300) ? 500 : (i < 320) ? 1000 : 500;
      test_frame("falling_pre_step", 1, 1, 800, 1'b1, 0, 1'b0);
   endtask

   task automatic test_falling_step();
      int k;
      do_reset();
      k = int'($urandom_range(260, 900));
      for (int i = 0; i < SLEN; i++) s[i] = (i < k) ? 1000 : 500;
      test_frame("falling_step", 3, 1, 800, 1'b1, 1, 1'b0);
   endtask

   task automatic test_auto();
      int q0;
      do_reset();
      for (int i = 0; i < SLEN; i++) s[i] = 100;
      test_frame("auto", 0, 0, 2000, 1'b1, 0, 1'b0);
      repeat (4) tick();
      tests++;
      if ((busy !== 1'b1) || (triggered !== 1'b0)) begin
         fails++;
         $display("FAIL auto_rearm: busy=%b triggered=%b, required busy=1 triggered=0", busy, triggered);
      end
      q0 = qa.size();
      feed(0, 5, 0);
      repeat (2) tick();
      tests++;
      if (qa.size() - q0 != 5) begin
         fails++;
         $display("FAIL auto_pretrig_writes: got %0d writes, required 5", qa.size() - q0);
      end
   endtask

   task automatic test_single_hold();
      int q0;
      do_reset();
      fill_random();
      test_frame("single", 2, int'($urandom_range(0, 1)), int'($urandom_range(500, 3500)),
                 1'b1, 1, 1'b1);
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL single_idle: busy=%b, required 0", busy);
      end
      q0 = qa.size();
      feed(0, 10, 0);
      repeat (2) tick();
      tests++;
      if (qa.size() != q0) begin
         fails++;
         $display("FAIL single_idle_writes: got %0d writes, required 0", qa.size() - q0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int tidx, efrc, r0;
      do_reset();
      for (int i = 0; i < SLEN; i++) s[i] = (i * 16) % 4096;
      mode = 2'b01; edge_sel = 1'b0; level = 12'd2048;
      model(1, 0, 2048, tidx, efrc);
      r0 = rom_cnt;
      pulse_arm();
      feed(0, tidx + 100, 1);
      sample = 12'(s[tidx + 100]);
      sample_valid = 1'b1;
      rst = 1'b1;
      tick();
      sample_valid = 1'b0;
      tests++;
      if ({wr_en, wr_addr, wr_data, start_addr, rom_read, busy, triggered, forced} !== '0) begin
         fails++;
         $display("FAIL midreset_outputs: wr_en=%b wr_addr=%0d wr_data=%0d start=%0d rom_read=%b busy=%b trig=%b forced=%b, required all 0",
                  wr_en, wr_addr, wr_data, start_addr, rom_read, busy, triggered, forced);
      end
      rst = 1'b0;
      exp_ptr = 0;
      repeat (30) tick();
      tests++;
      if ((rom_cnt != r0) || (busy !== 1'b0)) begin
         fails++;
         $display("FAIL midreset_no_rom: rom_reads=%0d busy=%b, required 0 and 0", rom_cnt - r0, busy);
      end
      fill_random();
      test_frame("after_reset", 1, 0, int'($urandom_range(500, 3500)), 1'b1, 1, 1'b0);
   endtask

   task automatic test_valid_toggle_wrap();
      int b0, q0, wraps;
      do_reset();
      b0 = b2b_wr;
      q0 = qa.size();
      fill_random();
      test_frame("toggle1", 1, 0, int'($urandom_range(500, 3500)), 1'b1, 2, 1'b0);
      fill_random();
      test_frame("toggle2", 1, 1, int'($urandom_range(500, 3500)), 1'b0, 2, 1'b0);
      tests++;
      if (b2b_wr != b0) begin
         fails++;
         $display("FAIL toggle_wr_en: %0d back-to-back writes, required 0", b2b_wr - b0);
      end
      wraps = 0;
      for (int i = q0 + 1; i < qa.size(); i++)
         if ((qa[i-1] == 9'd511) && (qa[i] == 9'd0)) wraps++;
      tests++;
      if (wraps < 2) begin
         fails++;
         $display("FAIL toggle_wrap: %0d 511->0 wraps seen, required at least 2", wraps);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         do_reset();
         fill_random();
         test_frame("random", ($urandom_range(0, 1) == 0) ? 1 : 3, int'($urandom_range(0, 1)),
                    int'($urandom_range(500, 3500)), 1'b1, 1, 1'b0);
      end
   endtask

   initial begin
      tick(); tick();
      test_reset();
      test_rising_ramp();
      test_falling_pretrig_step();
      test_falling_step();
      test_auto();
      test_single_hold();
      test_reset_mid_frame();
      test_valid_toggle_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
